// File: rtl/traffic_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// traffic_run_ctrl_pkg
// Shared definitions for the NoC traffic-run sequencer and the PE-side benches:
//   - run_state_e : run sequencer states IDLE/WARMUP/INJECT/DRAIN/DONE
//   - COUNT_W     : width of every packet/cycle counter (32)
//   - pe_coord_t / pe_index_to_xy : PE index i = y*X + x  ->  (x, y)
//   - sat_inc     : saturating counter increment
// -----------------------------------------------------------------------------
package traffic_run_ctrl_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_INJECT = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } run_state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pe_coord_t;

  // PEs are numbered row-major: i = y*x_dim + x.
  function automatic pe_coord_t pe_index_to_xy(input int unsigned idx,
                                               input int unsigned x_dim);
    pe_coord_t c;
    c.x = 16'(idx % x_dim);
    c.y = 16'(idx / x_dim);
    return c;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (v == {COUNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/traffic_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// traffic_run_ctrl_if
// Bundle between the run sequencer and the PE array / bench.
//   go, abort          : run control from the bench
//   pe_done[N]         : per-PE "finished sending" flags
//   pe_rx_count[32*N]  : per-PE received-packet counters, PE i at [32*i +: 32]
//   start              : run-active level to all PEs
//   enable_send[N]     : per-PE send slot
//   run_done, timeout  : sticky completion status
//   cycle_count        : INJECT + DRAIN cycles of the current/last run
//   total_rx           : sum of pe_rx_count from the last completed scan
// master = bench/PE side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface traffic_run_ctrl_if #(
  parameter int N = 16
);

  logic            go;
  logic            abort;
  logic [N-1:0]    pe_done;
  logic [32*N-1:0] pe_rx_count;
  logic            start;
  logic [N-1:0]    enable_send;
  logic            run_done;
  logic            timeout;
  logic [31:0]     cycle_count;
  logic [31:0]     total_rx;

  modport master (
    output go, abort, pe_done, pe_rx_count,
    input  start, enable_send, run_done, timeout, cycle_count, total_rx
  );

  modport slave (
    input  go, abort, pe_done, pe_rx_count,
    output start, enable_send, run_done, timeout, cycle_count, total_rx
  );

endinterface

// File: rtl/traffic_run_ctrl_rx_count_scanner.sv
// -----------------------------------------------------------------------------
// traffic_run_ctrl_rx_count_scanner
// Serial N-way accumulator over the per-PE received counters: one counter is
// added per enabled cycle, so a full scan takes N cycles.
//   clk, rstn    : clock, synchronous active-low reset
//   i_clr        : hold index/accumulator at zero (scan restarts from PE 0)
//   i_en         : scan active
//   i_counts     : N packed COUNT_W-bit counters, PE i at [COUNT_W*i +: COUNT_W]
//   o_index      : PE currently being added
//   o_sum_valid  : high in the cycle that adds the last PE
//   o_sum        : running sum including the current PE (full total when valid)
// After the last PE the accumulator clears and the next scan begins by itself.
// -----------------------------------------------------------------------------
module traffic_run_ctrl_rx_count_scanner #(
  parameter  int N       = 16,
  parameter  int COUNT_W = 32,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [COUNT_W*N-1:0] i_counts,
  output logic [IDX_W-1:0]     o_index,
  output logic                 o_sum_valid,
  output logic [COUNT_W-1:0]   o_sum
);

  logic [IDX_W-1:0]   r_idx;
  logic [COUNT_W-1:0] r_acc;
  logic [COUNT_W-1:0] w_counts [N];
  logic [COUNT_W-1:0] w_sum;
  logic               w_last;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_counts[g] = i_counts[g*COUNT_W +: COUNT_W];
  end

  assign w_last      = (r_idx == IDX_W'(N-1));
  assign w_sum       = r_acc + w_counts[r_idx];
  assign o_index     = r_idx;
  assign o_sum_valid = i_en & w_last;
  assign o_sum       = w_sum;

  // Index/accumulator: advance one PE per enabled cycle, wrap after PE N-1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx <= {IDX_W{1'b0}};
      r_acc <= {COUNT_W{1'b0}};
    end else if (i_clr) begin
      r_idx <= {IDX_W{1'b0}};
      r_acc <= {COUNT_W{1'b0}};
    end else if (i_en) begin
      if (w_last) begin
        r_idx <= {IDX_W{1'b0}};
        r_acc <= {COUNT_W{1'b0}};
      end else begin
        r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        r_acc <= w_sum;
      end
    end else begin
      r_idx <= r_idx;
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/traffic_run_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_run_ctrl
// Run sequencer for the X*Y array of traffic-generating PEs.
//   clk, rstn : clock, synchronous active-low reset
//   io_bus    : traffic_run_ctrl_if.slave (go/abort/pe_done/pe_rx_count in,
//               start/enable_send/run_done/timeout/cycle_count/total_rx out)
// Flow: IDLE --go--> WARMUP (WARMUP_CYCLES) --> INJECT (staggered enables, one
// slot per PE every RATE cycles) --all pe_done--> DRAIN (repeated serial scans
// of pe_rx_count until the sum hits X*Y*NUM_PKTS or DRAIN_TIMEOUT cycles pass)
// --> DONE (held while go stays high). abort in an active state ends the run
// with timeout set. All outputs are registered.
// -----------------------------------------------------------------------------
module traffic_run_ctrl
  import traffic_run_ctrl_pkg::*;
#(
  parameter int X             = 4,
  parameter int Y             = 4,
  parameter int NUM_PKTS      = 100,
  parameter int RATE          = 1,
  parameter int WARMUP_CYCLES = 16,
  parameter int DRAIN_TIMEOUT = 10000
) (
  input logic               clk,
  input logic               rstn,
  traffic_run_ctrl_if.slave io_bus
);

  localparam int N     = X * Y;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [COUNT_W-1:0] EXP_TOTAL  = COUNT_W'(longint'(N) * longint'(NUM_PKTS));
  localparam logic [COUNT_W-1:0] WARM_LAST  = (WARMUP_CYCLES > 0) ? COUNT_W'(WARMUP_CYCLES - 1)
                                                                  : {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] DRAIN_LAST = (DRAIN_TIMEOUT > 0) ? COUNT_W'(DRAIN_TIMEOUT - 1)
                                                                  : {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] RATE_LAST  = (RATE > 1) ? COUNT_W'(RATE - 1) : {COUNT_W{1'b0}};

  run_state_e         r_state;
  run_state_e         w_state_nxt;

  logic [COUNT_W-1:0] r_warm_cnt;
  logic [COUNT_W-1:0] r_phase;
  logic [COUNT_W-1:0] r_drain_cnt;
  logic               r_start;
  logic [N-1:0]       r_enable_send;
  logic               r_run_done;
  logic               r_timeout;
  logic [COUNT_W-1:0] r_cycle_count;
  logic [COUNT_W-1:0] r_total_rx;

  logic [COUNT_W-1:0] w_warm_nxt;
  logic [COUNT_W-1:0] w_phase_nxt;
  logic [COUNT_W-1:0] w_drain_nxt;
  logic               w_start_nxt;
  logic [N-1:0]       w_enable_nxt;
  logic               w_run_done_nxt;
  logic               w_timeout_nxt;
  logic [COUNT_W-1:0] w_cycle_nxt;
  logic [COUNT_W-1:0] w_total_nxt;

  logic               w_accept;
  logic               w_active;
  logic               w_abort;
  logic               w_all_done;
  logic               w_warm_last;
  logic               w_drain_last;
  logic               w_scan_valid;
  logic [COUNT_W-1:0] w_scan_sum;
  logic               w_sum_ok;
  logic [N-1:0]       w_phase_en;
  logic [IDX_W-1:0]   w_unused_scan_idx;  // scan position, kept for debug visibility

  assign w_accept     = (r_state == ST_IDLE) & io_bus.go;
  assign w_active     = (r_state == ST_WARMUP) | (r_state == ST_INJECT) | (r_state == ST_DRAIN);
  assign w_abort      = w_active & io_bus.abort;
  assign w_all_done   = &io_bus.pe_done;
  assign w_warm_last  = (r_warm_cnt == WARM_LAST);
  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);
  assign w_sum_ok     = (w_scan_sum == EXP_TOTAL);

  // PE i owns phase i%RATE; a PE that reports done loses its slot.
  for (genvar g = 0; g < N; g++) begin : g_phase
    assign w_phase_en[g] = (r_phase == COUNT_W'(g % RATE)) & ~io_bus.pe_done[g];
  end

  // The scanner only runs in DRAIN and restarts from PE 0 on every entry.
  traffic_run_ctrl_rx_count_scanner #(
    .N       (N),
    .COUNT_W (COUNT_W)
  ) u_scanner (
    .clk         (clk),
    .rstn        (rstn),
    .i_clr       (r_state != ST_DRAIN),
    .i_en        (r_state == ST_DRAIN),
    .i_counts    (io_bus.pe_rx_count),
    .o_index     (w_unused_scan_idx),
    .o_sum_valid (w_scan_valid),
    .o_sum       (w_scan_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks everything, drain timeout outranks a good scan.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.go) begin
          w_state_nxt = ST_WARMUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (io_bus.abort) begin
          w_state_nxt = ST_DONE;
        end else if (w_warm_last) begin
          w_state_nxt = ST_INJECT;
        end else begin
          w_state_nxt = ST_WARMUP;
        end
      end
      ST_INJECT: begin
        if (io_bus.abort) begin
          w_state_nxt = ST_DONE;
        end else if (w_all_done) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_INJECT;
        end
      end
      ST_DRAIN: begin
        if (io_bus.abort || w_drain_last) begin
          w_state_nxt = ST_DONE;
        end else if (w_scan_valid && w_sum_ok) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        // go must drop before another run can be accepted
        if (io_bus.go) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and of the run counters.
  always_comb begin
    w_start_nxt = (w_state_nxt == ST_WARMUP) | (w_state_nxt == ST_INJECT) |
                  (w_state_nxt == ST_DRAIN);

    // Enables drop on the same edge that leaves INJECT.
    if ((r_state == ST_INJECT) && (w_state_nxt == ST_INJECT)) begin
      w_enable_nxt = w_phase_en;
    end else begin
      w_enable_nxt = {N{1'b0}};
    end

    if (w_accept) begin
      w_run_done_nxt = 1'b0;
    end else if ((r_state != ST_DONE) && (w_state_nxt == ST_DONE)) begin
      w_run_done_nxt = 1'b1;
    end else begin
      w_run_done_nxt = r_run_done;
    end

    if (w_accept) begin
      w_timeout_nxt = 1'b0;
    end else if (w_abort || ((r_state == ST_DRAIN) && w_drain_last)) begin
      w_timeout_nxt = 1'b1;
    end else begin
      w_timeout_nxt = r_timeout;
    end

    if (w_accept) begin
      w_cycle_nxt = {COUNT_W{1'b0}};
    end else if ((r_state == ST_INJECT) || (r_state == ST_DRAIN)) begin
      w_cycle_nxt = sat_inc(r_cycle_count);
    end else begin
      w_cycle_nxt = r_cycle_count;
    end

    if (w_accept) begin
      w_total_nxt = {COUNT_W{1'b0}};
    end else if ((r_state == ST_DRAIN) && w_scan_valid) begin
      w_total_nxt = w_scan_sum;
    end else begin
      w_total_nxt = r_total_rx;
    end

    if ((r_state == ST_WARMUP) && !w_warm_last) begin
      w_warm_nxt = r_warm_cnt + 32'd1;
    end else begin
      w_warm_nxt = {COUNT_W{1'b0}};
    end

    if ((r_state == ST_INJECT) && (r_phase != RATE_LAST)) begin
      w_phase_nxt = r_phase + 32'd1;
    end else begin
      w_phase_nxt = {COUNT_W{1'b0}};
    end

    if (r_state == ST_DRAIN) begin
      w_drain_nxt = r_drain_cnt + 32'd1;
    end else begin
      w_drain_nxt = {COUNT_W{1'b0}};
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_start       <= 1'b0;
      r_enable_send <= {N{1'b0}};
      r_run_done    <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= {COUNT_W{1'b0}};
      r_total_rx    <= {COUNT_W{1'b0}};
      r_warm_cnt    <= {COUNT_W{1'b0}};
      r_phase       <= {COUNT_W{1'b0}};
      r_drain_cnt   <= {COUNT_W{1'b0}};
    end else begin
      r_start       <= w_start_nxt;
      r_enable_send <= w_enable_nxt;
      r_run_done    <= w_run_done_nxt;
      r_timeout     <= w_timeout_nxt;
      r_cycle_count <= w_cycle_nxt;
      r_total_rx    <= w_total_nxt;
      r_warm_cnt    <= w_warm_nxt;
      r_phase       <= w_phase_nxt;
      r_drain_cnt   <= w_drain_nxt;
    end
  end

  assign io_bus.start       = r_start;
  assign io_bus.enable_send = r_enable_send;
  assign io_bus.run_done    = r_run_done;
  assign io_bus.timeout     = r_timeout;
  assign io_bus.cycle_count = r_cycle_count;
  assign io_bus.total_rx    = r_total_rx;

endmodule

// File: tb/tb_traffic_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_run_ctrl
// Two sequencer instances share one clock:
//   dut_a : 2x2, RATE=2, WARMUP=4, NUM_PKTS=3  (stagger, abort, reset in DRAIN)
//   dut_b : 4x4, RATE=1, WARMUP=16, NUM_PKTS=100, DRAIN_TIMEOUT=50
//           (normal run, drain timeout, restart)
// Outputs are sampled 1 time unit after the rising edge; inputs change there.
// -----------------------------------------------------------------------------
module tb_traffic_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a;
  logic rstn_b;

  traffic_run_ctrl_if #(.N(4))  ifa ();
  traffic_run_ctrl_if #(.N(16)) ifb ();

  traffic_run_ctrl #(
    .X(2), .Y(2), .NUM_PKTS(3), .RATE(2), .WARMUP_CYCLES(4), .DRAIN_TIMEOUT(50)
  ) dut_a (
    .clk    (clk),
    .rstn   (rstn_a),
    .io_bus (ifa.slave)
  );

  traffic_run_ctrl #(
    .X(4), .Y(4), .NUM_PKTS(100), .RATE(1), .WARMUP_CYCLES(16), .DRAIN_TIMEOUT(50)
  ) dut_b (
    .clk    (clk),
    .rstn   (rstn_b),
    .io_bus (ifb.slave)
  );

  int total;
  int bad;
  int sent [16];
  int de;
  int fe;
  int done_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One run on dut_b with a PE model: each observed enable is one packet sent,
  // delivery is immediate; PE 'stuck' never reports more than 99 received.
  task automatic run_b(input int stuck, output int done_edge, output int first_en);
    done_edge = -1;
    first_en  = -1;
    for (int i = 0; i < 16; i++) sent[i] = 0;
    ifb.pe_done     = '0;
    ifb.pe_rx_count = '0;
    ifb.go          = 1'b1;
    for (int e = 1; e <= 2000 && done_edge < 0; e++) begin
      tick();
      if (e == 1) begin
        chk("b_accept_start", ifb.start, 1);
        chk("b_accept_run_done_clr", ifb.run_done, 0);
        chk("b_accept_timeout_clr", ifb.timeout, 0);
        chk("b_accept_cycle_clr", ifb.cycle_count, 0);
        chk("b_accept_total_clr", ifb.total_rx, 0);
      end
      if (first_en < 0 && ifb.enable_send != 16'h0000) first_en = e;
      for (int i = 0; i < 16; i++) begin
        if (ifb.enable_send[i]) sent[i]++;
        ifb.pe_done[i] = (sent[i] >= 100);
        ifb.pe_rx_count[32*i +: 32] = (i == stuck && sent[i] > 99) ? 32'd99 : 32'(sent[i]);
      end
      if (ifb.run_done) done_edge = e;
    end
    chk("b_run_within_budget", (done_edge > 0), 1);
    ifb.go = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    ifa.go = 1'b0; ifa.abort = 1'b0; ifa.pe_done = '0; ifa.pe_rx_count = '0;
    ifb.go = 1'b0; ifb.abort = 1'b0; ifb.pe_done = '0; ifb.pe_rx_count = '0;
    repeat (3) tick();
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    repeat (20) tick();

    // reset / idle
    chk("a_rst_start", ifa.start, 0);
    chk("a_rst_enable", ifa.enable_send, 0);
    chk("a_rst_run_done", ifa.run_done, 0);
    chk("a_rst_timeout", ifa.timeout, 0);
    chk("a_rst_total", ifa.total_rx, 0);
    chk("a_rst_cycles", ifa.cycle_count, 0);
    chk("b_rst_start", ifb.start, 0);
    chk("b_rst_enable", ifb.enable_send, 0);
    chk("b_rst_run_done", ifb.run_done, 0);
    chk("b_rst_total", ifb.total_rx, 0);

    // rate stagger: start at edge 1, enables from edge 6, phases alternate
    ifa.go = 1'b1;
    tick();
    chk("a_go_start", ifa.start, 1);
    chk("a_go_enable", ifa.enable_send, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("a_warmup_enable", ifa.enable_send, 0);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("a_stagger", ifa.enable_send, (k % 2 == 0) ? 4'b0101 : 4'b1010);
    end
    ifa.pe_done = 4'b0010;
    tick();
    chk("a_mask_even", ifa.enable_send, 4'b0101);
    tick();
    chk("a_mask_odd", ifa.enable_send, 4'b1000);
    chk("a_inject_cycles", ifa.cycle_count, 8);

    // abort in INJECT
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    chk("a_abort_start", ifa.start, 0);
    chk("a_abort_timeout", ifa.timeout, 1);
    chk("a_abort_run_done", ifa.run_done, 1);
    chk("a_abort_enable", ifa.enable_send, 0);
    chk("a_abort_cycles", ifa.cycle_count, 9);
    tick();
    chk("a_done_hold_go_high", ifa.start, 0);
    ifa.go = 1'b0;
    tick();
    chk("a_idle_run_done_held", ifa.run_done, 1);
    chk("a_idle_timeout_held", ifa.timeout, 1);

    // second run on dut_a, reset while in DRAIN
    ifa.go = 1'b1;
    ifa.pe_done = 4'b1111;
    for (int i = 0; i < 4; i++) ifa.pe_rx_count[32*i +: 32] = 32'(i + 1);
    tick();
    chk("a_restart_start", ifa.start, 1);
    chk("a_restart_run_done_clr", ifa.run_done, 0);
    chk("a_restart_timeout_clr", ifa.timeout, 0);
    chk("a_restart_cycles_clr", ifa.cycle_count, 0);
    repeat (10) tick();
    chk("a_drain_start", ifa.start, 1);
    chk("a_drain_enable", ifa.enable_send, 0);
    chk("a_drain_partial_total", ifa.total_rx, 10);
    chk("a_drain_run_done", ifa.run_done, 0);
    chk("a_drain_cycles", ifa.cycle_count, 6);
    ifa.go = 1'b0;
    rstn_a = 1'b0;
    tick();
    chk("a_midrst_start", ifa.start, 0);
    chk("a_midrst_enable", ifa.enable_send, 0);
    chk("a_midrst_run_done", ifa.run_done, 0);
    chk("a_midrst_timeout", ifa.timeout, 0);
    chk("a_midrst_total", ifa.total_rx, 0);
    chk("a_midrst_cycles", ifa.cycle_count, 0);
    rstn_a = 1'b1;
    tick();
    chk("a_postrst_idle", ifa.start, 0);

    // full run on dut_a: all PEs done, every counter at 3 -> total 12
    for (int i = 0; i < 4; i++) ifa.pe_rx_count[32*i +: 32] = 32'd3;
    ifa.go = 1'b1;
    done_a = -1;
    for (int e = 1; e <= 100 && done_a < 0; e++) begin
      tick();
      if (ifa.run_done) done_a = e;
    end
    chk("a_done_edge", done_a, 10);
    chk("a_done_total", ifa.total_rx, 12);
    chk("a_done_timeout", ifa.timeout, 0);
    chk("a_done_start", ifa.start, 0);
    chk("a_done_cycles", ifa.cycle_count, 5);
    ifa.go = 1'b0;

    // dut_b normal completion
    run_b(-1, de, fe);
    chk("b1_first_enable_edge", fe, 18);
    chk("b1_done_edge", de, 134);
    chk("b1_total", ifb.total_rx, 1600);
    chk("b1_run_done", ifb.run_done, 1);
    chk("b1_timeout", ifb.timeout, 0);
    chk("b1_start", ifb.start, 0);
    chk("b1_enable", ifb.enable_send, 0);
    chk("b1_cycles", ifb.cycle_count, 117);

    // dut_b drain timeout: PE 5 stuck at 99
    run_b(5, de, fe);
    chk("b2_done_edge", de, 168);
    chk("b2_total", ifb.total_rx, 1599);
    chk("b2_run_done", ifb.run_done, 1);
    chk("b2_timeout", ifb.timeout, 1);
    chk("b2_cycles", ifb.cycle_count, 151);

    // dut_b restart: identical to the first run
    run_b(-1, de, fe);
    chk("b3_done_edge", de, 134);
    chk("b3_total", ifb.total_rx, 1600);
    chk("b3_timeout", ifb.timeout, 0);
    chk("b3_cycles", ifb.cycle_count, 117);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_run_ctrl.md
Name: traffic_run_ctrl

Overview:
- Testbench-side run sequencer for the X*Y array of traffic-generating PEs on the NoC.
- Owns each PE's start and enableSend strobes and applies a staggered injection-rate schedule.
- Detects when every PE has finished sending, then waits for the network to drain: it polls every PE's received-packet counter until the total equals X*Y*NUM_PKTS or a timeout expires.
- Reports completion, timeout, elapsed cycles and total packets received.

Parameters:
- X, 4, mesh columns.
- Y, 4, mesh rows.
- N, X*Y, PE count (derived; do not override).
- NUM_PKTS, 100, packets each PE transmits; expected total = N*NUM_PKTS.
- RATE, 1, injection period in cycles (RATE>=1); each PE gets one send slot per RATE cycles.
- WARMUP_CYCLES, 16, cycles after start rises before any enable_send.
- DRAIN_TIMEOUT, 10000, maximum cycles spent in DRAIN.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- go  in  1  level; sampled in IDLE to begin a run.
- abort  in  1  forces an immediate end of the run.
- pe_done  in  N  per-PE done flag (bit i = PE i = y*X+x).
- pe_rx_count  in  32*N  per-PE received count; PE i occupies bits [32*i+31:32*i].
- start  out  1  run-active level to all PEs; its falling edge triggers the PE reports.
- enable_send  out  N  per-PE send enable.
- run_done  out  1  run finished (sticky).
- timeout  out  1  run ended by DRAIN_TIMEOUT or abort (sticky).
- cycle_count  out  32  cycles spent in INJECT plus DRAIN.
- total_rx  out  32  sum of pe_rx_count from the last completed scan.

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE. start, enable_send, run_done, timeout, cycle_count and total_rx are all 0. Internal counters are cleared.
- Reset mid-run: everything returns to the reset values on the next edge and start drops. Aborting a run this way is legal.
- IDLE:
  - go=1 -> WARMUP next cycle; start<=1.
  - Entry from IDLE clears run_done, timeout, cycle_count and total_rx.
- WARMUP:
  - enable_send=0; the warm counter runs 0..WARMUP_CYCLES-1, then -> INJECT.
  - WARMUP_CYCLES=0 -> INJECT directly after one WARMUP cycle.
- INJECT:
  - Phase counter p runs 0..RATE-1 and wraps to 0. It resets to 0 on INJECT entry.
  - enable_send[i] is registered: it equals (p==i%RATE) & ~pe_done[i], updated each cycle.
  - RATE=1 -> every not-done PE is enabled every cycle.
  - When &pe_done==1 -> DRAIN; enable_send<=0 on the same edge.
- DRAIN:
  - Serial scan: index k runs 0..N-1 and the accumulator adds pe_rx_count[k] each cycle, so one scan takes N cycles.
  - At k=N-1 the total is latched into total_rx and the accumulator is cleared.
  - If the latched sum == N*NUM_PKTS -> DONE; otherwise a new scan starts.
  - The drain counter increments each DRAIN cycle. Reaching DRAIN_TIMEOUT -> DONE with timeout<=1. This has priority over a scan completing on the same cycle.
- DONE:
  - start<=0, enable_send=0, run_done<=1.
  - Stays in DONE while go=1; go=0 -> IDLE.
  - run_done, timeout, total_rx and cycle_count hold until the next run is accepted.
- abort=1 in WARMUP, INJECT or DRAIN -> DONE next edge with timeout<=1. abort in IDLE or DONE is ignored.
- go in any non-IDLE state is ignored. go held high after DONE does not restart a run; go must return low first.
- cycle_count increments once per cycle in INJECT or DRAIN and saturates at 32'hFFFF_FFFF.
- Arithmetic:
  - The accumulator is 32 bits and wraps modulo 2^32; the bench keeps N*NUM_PKTS < 2^32.
  - The expected-total constant is computed at elaboration.
- Latency: go -> start = 1 cycle. The first enable_send is at WARMUP_CYCLES+1 cycles after start rises.

Decomposition:
- Shared package (noc_tb_pkg) holds:
  - state enumeration IDLE/WARMUP/INJECT/DRAIN/DONE;
  - the COUNT_W=32 constant;
  - the function mapping PE index to (x,y), shared with the PE-side benches.
- One sub-module, rx_count_scanner: serial N-way accumulator with start/clear, index, sum_valid pulse and sum outputs. The FSM, phase counter, warm/drain counters and status registers stay in the top.

Test Plan:
- Reset/idle: go=0 for 20 cycles after rstn rises -> start=0, enable_send=0, run_done=0, timeout=0, total_rx=0.
- Rate stagger: X=Y=2, RATE=2, WARMUP_CYCLES=4, go=1, pe_done=0 -> start at cycle 1. The first enable_send is at cycle 6, with PEs 0 and 2 enabled on even phases and PEs 1 and 3 on odd phases; the pattern alternates exactly.
- Normal completion: NUM_PKTS=100, N=16, model PEs count packets; all pe_done rise and pe_rx_count reaches 100 each -> within 2*16 cycles total_rx=1600, run_done=1, timeout=0, start falls.
- Drain timeout: DRAIN_TIMEOUT=50, one PE's rx count stuck at 99 -> DONE after 50 DRAIN cycles with timeout=1, run_done=1, total_rx=1599.
- Abort and reset mid-run: abort=1 in INJECT -> next cycle start=0, timeout=1, enable_send=0. Separately, rstn=0 in DRAIN -> all outputs 0 next edge and state IDLE.
- Restart: after DONE, go=0 for 1 cycle then go=1 -> run_done, timeout and cycle_count clear and a second full run completes with identical total_rx.
